countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counting timer; the counterpart of the team's free-running up-counting modulo timer.
- Counts from a programmed value down to zero on qualified ticks (enable), then pulses done.
- Start/stop control with pause/resume.
- Used for timeouts, delays and one-shot intervals in the same designs that use the up-counting timer as a tick source.

Parameters:
- BITS, 8, width of the load value and the count output; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  tick qualifier; the count decrements only on cycles where enable=1 in RUN.
- start  input  1  level-sampled each cycle; in IDLE loads load_value and runs; in PAUSED resumes.
- stop  input  1  in RUN pauses; in PAUSED aborts to IDLE.
- load_value  input  BITS  interval, sampled on the cycle start is accepted from IDLE.
- Q  output  BITS  current remaining count (registered).
- busy  output  1  high in RUN and PAUSED (registered).
- done  output  1  single-cycle pulse at terminal count (registered).

Behaviour:
- Reset: when reset=1 at a clock edge, state=IDLE, Q=0, busy=0, done=0, latched reload value=0. This applies from any state, including mid-count; no done pulse is generated.
- States: IDLE, RUN, PAUSED. State is held in registers; all outputs are registered, with no combinational path from inputs to outputs.
- IDLE:
  - start=1, stop=0, load_value=L>=1 -> next cycle Q=L, busy=1, state RUN. L is latched as the reload value.
  - start=1, stop=0, L=0 -> next cycle done=1 for one cycle, Q=0, busy=0, state stays IDLE.
  - stop=1 is ignored in IDLE. Q holds its last value.
- RUN:
  - stop=1 (start ignored) -> PAUSED next cycle. Q holds; no decrement on that cycle, even if enable=1.
  - Else if enable=1 and Q>1 -> Q=Q-1.
  - Else if enable=1 and Q==1 -> Q=0, done=1 the same cycle Q shows 0, busy=0, state IDLE.
  - enable=0 -> Q holds.
  - start=1 in RUN is ignored; there is no retrigger.
- PAUSED:
  - stop=1 has priority -> IDLE, Q=0, busy=0, no done.
  - Else start=1 -> RUN, Q unchanged.
  - Else hold.
- Priority when start and stop are both 1: stop wins in every state.
- Latency: start accepted at edge N -> Q=L after edge N. With enable held at 1, done=1 and Q=0 after edge N+L. Total interval is L enabled cycles after the load cycle.
- done is high for exactly one cycle per terminal event. It is never asserted on abort or reset.
- Q never wraps below 0. No arithmetic underflow is possible because the decrement is only performed for Q>=2.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined:
  - Adds input port auto_reload (1 bit).
  - At the terminal event with auto_reload=1: done pulses, Q is reloaded with the latched reload value on the same edge instead of 0, and state stays RUN with busy=1. The timer is periodic with period equal to the latched value in enabled ticks.
  - If auto_reload=0 at the terminal event, behaviour is one-shot as above.
  - stop still pauses and aborts normally.
- Not defined: port absent; the block is strictly one-shot.

Test Plan:
- Reset mid-run: load 10, run 3 ticks (Q=7), assert reset for 1 cycle -> Q=0, busy=0, done=0 next cycle; no done pulse afterwards.
- Basic one-shot: BITS=8, start with load_value=5, enable=1 continuous -> Q sequence 5,4,3,2,1,0; done=1 only on the cycle Q=0, 5 cycles after Q=5; busy falls with done.
- Enable gating: load 4, enable toggled 1,0,1,0,... -> Q decrements only on enable=1 cycles; done arrives after 4 enabled ticks.
- Pause/resume/abort:
  - load 8, stop at Q=6 -> Q holds 6 for 5 cycles in PAUSED with busy=1; start resumes to 5,4...
  - Second run: stop in PAUSED -> Q=0, busy=0, no done.
  - start+stop together in RUN -> PAUSED.
- Boundaries:
  - load 0 -> single done pulse, busy stays 0.
  - load 255 (BITS=8) -> done after 255 enabled ticks, no wrap.
  - start during RUN -> ignored, count unaffected.
- Auto-reload (macro defined): load 3, auto_reload=1, enable=1 -> Q 3,2,1,0→reload shows 3 on the terminal edge with done=1, repeating every 3 cycles. Drop auto_reload -> next terminal ends in IDLE with Q=0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer; master drives controls, slave returns Q/busy/done.
// COUNTDOWN_TIMER_AUTORELOAD_EN adds the auto_reload control.
interface countdown_timer_if #(
  parameter int BITS = 8
);
  logic            enable;
  logic            start;
  logic            stop;
  logic [BITS-1:0] load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic            auto_reload;
`endif
  logic [BITS-1:0] Q;
  logic            busy;
  logic            done;

  modport master (
    output enable, start, stop, load_value,
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    output auto_reload,
`endif
    input  Q, busy, done
  );

  modport slave (
    input  enable, start, stop, load_value,
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    input  auto_reload,
`endif
    output Q, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter: Q=L one cycle after start, done pulses L enabled ticks later; stop pauses/aborts,
// all outputs registered, no backpressure. Optional periodic mode under COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer #(
  parameter int BITS = 8
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave tmr
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] q_q, q_d;
  logic [BITS-1:0] reload_q, reload_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            auto_reload;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  assign auto_reload = tmr.auto_reload;
`else
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tmr.start && !tmr.stop) begin
          if (tmr.load_value == '0) begin
            // zero-length interval: immediate terminal event without leaving IDLE
            done_d = 1'b1;
            q_d    = '0;
          end else begin
            state_d  = RUN;
            q_d      = tmr.load_value;
            reload_d = tmr.load_value;
            busy_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (tmr.stop) begin
          state_d = PAUSED;
        end else if (tmr.enable) begin
          if (q_q > BITS'(1)) begin
            q_d = q_q - BITS'(1);
          end else begin
            done_d = 1'b1;
            if (auto_reload) begin
              q_d = reload_q;
            end else begin
              state_d = IDLE;
              q_d     = '0;
              busy_d  = 1'b0;
            end
          end
        end
      end
      PAUSED: begin
        if (tmr.stop) begin
          state_d = IDLE;
          q_d     = '0;
          busy_d  = 1'b0;
        end else if (tmr.start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tmr.Q    = q_q;
  assign tmr.busy = busy_q;
  assign tmr.done = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed bench for countdown_timer against a behavioural reference model.
module tb_countdown_timer;
  localparam int BITS = 8;

  logic clk = 1'b0;
  logic reset;

  countdown_timer_if #(.BITS(BITS)) tif();

  countdown_timer #(.BITS(BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .tmr   (tif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: remaining count plus running/paused flags
  int m_q, m_reload;
  bit m_busy, m_paused, m_done;

  function automatic bit cur_ar();
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    return tif.auto_reload;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    m_done = 0;
    if (reset) begin
      m_q = 0; m_reload = 0; m_busy = 0; m_paused = 0;
    end else if (!m_busy) begin
      if (tif.start && !tif.stop) begin
        if (tif.load_value == 0) begin
          m_done = 1; m_q = 0;
        end else begin
          m_q = int'(tif.load_value); m_reload = m_q; m_busy = 1; m_paused = 0;
        end
      end
    end else if (m_paused) begin
      if (tif.stop) begin
        m_busy = 0; m_paused = 0; m_q = 0;
      end else if (tif.start) begin
        m_paused = 0;
      end
    end else if (tif.stop) begin
      m_paused = 1;
    end else if (tif.enable) begin
      m_q = m_q - 1;
      if (m_q == 0) begin
        m_done = 1;
        if (cur_ar()) m_q = m_reload;
        else m_busy = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    tif.enable = 0; tif.start = 0; tif.stop = 0; tif.load_value = '0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    tif.auto_reload = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic load(input int l);
    tif.start = 1; tif.load_value = BITS'(l); tick();
    tif.start = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; tick(); tick();
    checks++;
    if (tif.Q !== '0 || tif.busy !== 1'b0 || tif.done !== 1'b0) begin
      errors++; $display("FAIL reset_state Q=%0d busy=%b done=%b required 0/0/0", tif.Q, tif.busy, tif.done);
    end
    reset = 0;
    tif.enable = 1;
    load(10);
    repeat (3) tick();
    checks++;
    if (tif.Q !== BITS'(7) || tif.busy !== 1'b1) begin
      errors++; $display("FAIL reset_midrun_pre Q=%0d busy=%b required 7/1", tif.Q, tif.busy);
    end
    reset = 1; tick(); reset = 0;
    checks++;
    if (tif.Q !== '0 || tif.busy !== 1'b0 || tif.done !== 1'b0) begin
      errors++; $display("FAIL reset_midrun Q=%0d busy=%b done=%b required 0/0/0", tif.Q, tif.busy, tif.done);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (tif.done !== 1'b0 || tif.busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_done k=%0d done=%b busy=%b required 0/0", k, tif.done, tif.busy);
      end
    end
  endtask

  task automatic test_one_shot();
    do_reset();
    tif.enable = 1;
    load(5);
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (tif.Q !== BITS'(5 - k) || tif.done !== (k == 5) || tif.busy !== (k < 5)) begin
        errors++; $display("FAIL one_shot k=%0d Q=%0d done=%b busy=%b required Q=%0d", k, tif.Q, tif.done, tif.busy, 5 - k);
      end
      if (k < 5) tick();
    end
    tick();
    checks++;
    if (tif.done !== 1'b0 || tif.Q !== '0) begin
      errors++; $display("FAIL one_shot_after done=%b Q=%0d required 0/0", tif.done, tif.Q);
    end
  endtask

  task automatic test_enable_gating();
    int en_ticks, done_at;
    do_reset();
    load(4);
    en_ticks = 0; done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      tif.enable = (i % 2 == 0);
      if (tif.enable) en_ticks++;
      tick();
      checks++;
      if (tif.Q !== BITS'(m_q) || tif.busy !== m_busy || tif.done !== m_done) begin
        errors++; $display("FAIL enable_gating i=%0d Q=%0d busy=%b done=%b required %0d/%b/%b", i, tif.Q, tif.busy, tif.done, m_q, m_busy, m_done);
      end
      if (tif.done === 1'b1) done_at = en_ticks;
    end
    checks++;
    if (done_at != 4) begin
      errors++; $display("FAIL enable_gating_ticks got=%0d required 4", done_at);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    tif.enable = 1;
    load(8);
    tick(); tick();
    tif.stop = 1; tick(); tif.stop = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (tif.Q !== BITS'(6) || tif.busy !== 1'b1 || tif.done !== 1'b0) begin
        errors++; $display("FAIL paused_hold k=%0d Q=%0d busy=%b required 6/1", k, tif.Q, tif.busy);
      end
    end
    tif.start = 1; tick(); tif.start = 0;
    tick();
    checks++;
    if (tif.Q !== BITS'(5) || tif.busy !== 1'b1) begin
      errors++; $display("FAIL resume Q=%0d busy=%b required 5/1", tif.Q, tif.busy);
    end
    tif.stop = 1; tick(); tick(); tif.stop = 0;
    checks++;
    if (tif.Q !== '0 || tif.busy !== 1'b0 || tif.done !== 1'b0) begin
      errors++; $display("FAIL abort Q=%0d busy=%b done=%b required 0/0/0", tif.Q, tif.busy, tif.done);
    end
    load(8);
    tick();
    tif.start = 1; tif.stop = 1; tick(); tif.start = 0; tif.stop = 0;
    tick(); tick();
    checks++;
    if (tif.Q !== BITS'(7) || tif.busy !== 1'b1) begin
      errors++; $display("FAIL start_stop_run Q=%0d busy=%b required 7/1", tif.Q, tif.busy);
    end
  endtask

  task automatic test_boundaries();
    int done_at;
    do_reset();
    tif.enable = 1;
    load(0);
    checks++;
    if (tif.done !== 1'b1 || tif.busy !== 1'b0 || tif.Q !== '0) begin
      errors++; $display("FAIL load_zero done=%b busy=%b Q=%0d required 1/0/0", tif.done, tif.busy, tif.Q);
    end
    tick();
    checks++;
    if (tif.done !== 1'b0 || tif.busy !== 1'b0) begin
      errors++; $display("FAIL load_zero_after done=%b busy=%b required 0/0", tif.done, tif.busy);
    end
    load(255);
    done_at = -1;
    for (int i = 1; i <= 300 && done_at < 0; i++) begin
      tick();
      checks++;
      if (tif.Q !== BITS'(m_q) || tif.busy !== m_busy || tif.done !== m_done) begin
        errors++; $display("FAIL load_max i=%0d Q=%0d busy=%b done=%b required %0d/%b/%b", i, tif.Q, tif.busy, tif.done, m_q, m_busy, m_done);
      end
      if (tif.done === 1'b1) done_at = i;
    end
    checks++;
    if (done_at != 255) begin
      errors++; $display("FAIL load_max_ticks got=%0d required 255", done_at);
    end
    load(20);
    tif.start = 1; tif.load_value = BITS'(3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (tif.Q !== BITS'(20 - k) || tif.busy !== 1'b1) begin
        errors++; $display("FAIL start_in_run k=%0d Q=%0d busy=%b required %0d/1", k, tif.Q, tif.busy, 20 - k);
      end
    end
    tif.start = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      tif.enable     = ($urandom_range(0, 3) != 0);
      tif.start      = ($urandom_range(0, 5) == 0);
      tif.stop       = ($urandom_range(0, 11) == 0);
      tif.load_value = ($urandom_range(0, 7) == 0) ? BITS'($urandom) : BITS'($urandom_range(0, 12));
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      tif.auto_reload = ($urandom_range(0, 1) == 0);
`endif
      tick();
      checks++;
      if (tif.Q !== BITS'(m_q) || tif.busy !== m_busy || tif.done !== m_done) begin
        errors++; $display("FAIL random i=%0d Q=%0d busy=%b done=%b required %0d/%b/%b", i, tif.Q, tif.busy, tif.done, m_q, m_busy, m_done);
      end
    end
    reset = 0;
  endtask

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    do_reset();
    tif.enable = 1; tif.auto_reload = 1;
    load(3);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (tif.Q !== BITS'(3 - (k % 3)) || tif.done !== (k % 3 == 0) || tif.busy !== 1'b1) begin
        errors++; $display("FAIL autoreload k=%0d Q=%0d done=%b busy=%b required Q=%0d", k, tif.Q, tif.done, tif.busy, 3 - (k % 3));
      end
    end
    tif.auto_reload = 0;
    tick(); tick(); tick();
    checks++;
    if (tif.Q !== '0 || tif.done !== 1'b1 || tif.busy !== 1'b0) begin
      errors++; $display("FAIL autoreload_off Q=%0d done=%b busy=%b required 0/1/0", tif.Q, tif.done, tif.busy);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_one_shot();
    test_enable_gating();
    test_pause_resume();
    test_boundaries();
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
